sfp_tx_link_ctrl: RTL and testbench

Link bring-up and fault-recovery sequencer for the master-side SFP transmit path. Runs the SFP transmitter through power-up, laser warm-up and comma sync before data is allowed, and inserts periodic resync commas. On a filtered TX fault it gates the driver, disables the laser, waits, and retries up to a limit before latching lockout. It sits between the 1 MHz frame-slot timing and the SFP/driver pins, and tells the frame serializer whether each slot carries a K28.5 comma or a data frame.

---
 rtl/sfp_tx_link_ctrl_if.sv | 28 ++
 rtl/sfp_tx_link_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_sfp_tx_link_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sfp_tx_link_ctrl_if.sv
// Pin and slot-timing bundle between the SFP transmit link sequencer and its surroundings.
// The sequencer uses the slave modport; the frame-slot/pin environment uses master.
interface sfp_tx_link_ctrl_if;
  logic       i_en;
  logic       i_clr_lockout;
  logic       i_slot_en;
  logic       i_sfp_tx_flt;
  logic       o_sfp_tx_dis;
  logic       o_drv_en;
  logic       o_send_comma;
  logic       o_data_valid;
  logic [2:0] o_state;
  logic [3:0] o_retry_cnt;
  logic       o_lockout;
  logic [1:0] o_tx_led;

  modport master (
    output i_en, i_clr_lockout, i_slot_en, i_sfp_tx_flt,
    input  o_sfp_tx_dis, o_drv_en, o_send_comma, o_data_valid,
    input  o_state, o_retry_cnt, o_lockout, o_tx_led
  );

  modport slave (
    input  i_en, i_clr_lockout, i_slot_en, i_sfp_tx_flt,
    output o_sfp_tx_dis, o_drv_en, o_send_comma, o_data_valid,
    output o_state, o_retry_cnt, o_lockout, o_tx_led
  );
endinterface

// File: rtl/sfp_tx_link_ctrl.sv
// SFP transmit link bring-up / fault-recovery sequencer: power-up, warm-up, comma sync,
// run with periodic resync commas, filtered-fault retry with lockout.
module sfp_tx_link_ctrl #(
  parameter int unsigned P_DIS_SLOTS      = 100,
  parameter int unsigned P_WARM_SLOTS     = 1000,
  parameter int unsigned P_SYNC_FRAMES    = 16,
  parameter int unsigned P_COMMA_PERIOD   = 256,
  parameter int unsigned P_FLT_FILT       = 4,
  parameter int unsigned P_FLT_HOLD_SLOTS = 10000,
  parameter int unsigned P_STABLE_SLOTS   = 1000,
  parameter int unsigned P_MAX_RETRY      = 3
) (
  input logic               i_clk,
  input logic               i_res_n,
  sfp_tx_link_ctrl_if.slave link
);

  localparam int unsigned CntW = 16;
  localparam int unsigned FltW = $clog2(P_FLT_FILT + 1);

  typedef enum logic [2:0] {
    StDisabled = 3'd0,
    StPowerup  = 3'd1,
    StWarmup   = 3'd2,
    StSync     = 3'd3,
    StRun      = 3'd4,
    StFault    = 3'd5,
    StLockout  = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] slot_cnt_q, slot_cnt_d;
  logic [CntW-1:0] stable_cnt_q, stable_cnt_d;
  logic [CntW-1:0] phase_q, phase_d;
  logic            comma_q, comma_d;
  logic [3:0]      retry_q, retry_d;
  logic [3:0]      retry_inc;
  logic [FltW-1:0] flt_cnt_q, flt_cnt_d;
  logic            flt_q, flt_d;
  logic            slot_en;
  logic            fault_entry;

  assign slot_en = link.i_slot_en;

  // Run-length of raw fault; flt_d is the filtered fault as it will be after this edge.
  always_comb begin
    flt_cnt_d = '0;
    if (link.i_sfp_tx_flt) begin
      flt_cnt_d = (flt_cnt_q == FltW'(P_FLT_FILT)) ? flt_cnt_q : flt_cnt_q + FltW'(1);
    end
    flt_d = (flt_cnt_d == FltW'(P_FLT_FILT));
  end

  assign retry_inc   = (retry_q == 4'hf) ? retry_q : retry_q + 4'd1;
  assign fault_entry = flt_d && (state_q == StWarmup || state_q == StSync || state_q == StRun);

  always_comb begin
    state_d      = state_q;
    slot_cnt_d   = slot_cnt_q;
    stable_cnt_d = (state_q == StRun) ? stable_cnt_q : '0;
    phase_d      = phase_q;
    comma_d      = comma_q;
    retry_d      = retry_q;

    if (!link.i_en && state_q != StLockout) begin
      state_d    = StDisabled;
      slot_cnt_d = '0;
    end else if (fault_entry) begin
      // Fault entry is immediate, not slot-aligned, and beats any slot transition.
      retry_d      = retry_inc;
      slot_cnt_d   = '0;
      stable_cnt_d = '0;
      state_d      = (retry_inc > 4'(P_MAX_RETRY)) ? StLockout : StFault;
    end else begin
      unique case (state_q)
        StDisabled: begin
          if (slot_en) begin
            state_d    = StPowerup;
            slot_cnt_d = '0;
          end
        end
        StPowerup: begin
          if (slot_en) begin
            if (slot_cnt_q == CntW'(P_DIS_SLOTS - 1)) begin
              state_d    = StWarmup;
              slot_cnt_d = '0;
            end else begin
              slot_cnt_d = slot_cnt_q + CntW'(1);
            end
          end
        end
        StWarmup: begin
          if (slot_en) begin
            if (slot_cnt_q == CntW'(P_WARM_SLOTS - 1)) begin
              state_d    = StSync;
              slot_cnt_d = '0;
            end else begin
              slot_cnt_d = slot_cnt_q + CntW'(1);
            end
          end
        end
        StSync: begin
          if (slot_en) begin
            if (slot_cnt_q == CntW'(P_SYNC_FRAMES - 1)) begin
              state_d    = StRun;
              slot_cnt_d = '0;
              phase_d    = CntW'(1);
              comma_d    = (P_COMMA_PERIOD == 1);
            end else begin
              slot_cnt_d = slot_cnt_q + CntW'(1);
            end
          end
        end
        StRun: begin
          if (slot_en) begin
            // phase_q is the 1-based position of the current slot within the comma period.
            phase_d = (phase_q >= CntW'(P_COMMA_PERIOD)) ? CntW'(1) : phase_q + CntW'(1);
            comma_d = (P_COMMA_PERIOD != 0) && (phase_d == CntW'(P_COMMA_PERIOD));
            if (stable_cnt_q != CntW'(P_STABLE_SLOTS)) begin
              stable_cnt_d = stable_cnt_q + CntW'(1);
            end
            if (stable_cnt_d == CntW'(P_STABLE_SLOTS)) begin
              retry_d = '0;
            end
          end
        end
        StFault: begin
          if (slot_en) begin
            if (flt_q) begin
              slot_cnt_d = '0;
            end else if (slot_cnt_q == CntW'(P_FLT_HOLD_SLOTS - 1)) begin
              state_d    = StPowerup;
              slot_cnt_d = '0;
            end else begin
              slot_cnt_d = slot_cnt_q + CntW'(1);
            end
          end
        end
        StLockout: begin
          if (link.i_clr_lockout) begin
            state_d    = StDisabled;
            slot_cnt_d = '0;
            retry_d    = '0;
          end
        end
        default: begin
          state_d    = StDisabled;
          slot_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_res_n) begin
      state_q      <= StDisabled;
      slot_cnt_q   <= '0;
      stable_cnt_q <= '0;
      phase_q      <= '0;
      comma_q      <= 1'b0;
      retry_q      <= '0;
      flt_cnt_q    <= '0;
      flt_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_cnt_q   <= slot_cnt_d;
      stable_cnt_q <= stable_cnt_d;
      phase_q      <= phase_d;
      comma_q      <= comma_d;
      retry_q      <= retry_d;
      flt_cnt_q    <= flt_cnt_d;
      flt_q        <= flt_d;
    end
  end

  logic       tx_dis, drv_en, send_comma, data_valid, lockout;
  logic [1:0] tx_led;

  always_comb begin
    tx_dis     = 1'b1;
    drv_en     = 1'b0;
    send_comma = 1'b0;
    data_valid = 1'b0;
    lockout    = 1'b0;
    tx_led     = 2'b00;
    unique case (state_q)
      StDisabled: ;
      StPowerup:  tx_led = 2'b11;
      StWarmup: begin
        tx_dis = 1'b0;
        tx_led = 2'b11;
      end
      StSync: begin
        tx_dis     = 1'b0;
        drv_en     = 1'b1;
        send_comma = 1'b1;
        tx_led     = 2'b11;
      end
      StRun: begin
        tx_dis     = 1'b0;
        drv_en     = 1'b1;
        send_comma = comma_q;
        data_valid = ~comma_q;
        tx_led     = 2'b10;
      end
      StFault:   tx_led = 2'b01;
      StLockout: begin
        lockout = 1'b1;
        tx_led  = 2'b01;
      end
      default: ;
    endcase
  end

  assign link.o_sfp_tx_dis = tx_dis;
  // Raw fault drops the driver immediately, independent of the filter.
  assign link.o_drv_en     = drv_en & ~link.i_sfp_tx_flt;
  assign link.o_send_comma = send_comma;
  assign link.o_data_valid = data_valid;
  assign link.o_state      = state_q;
  assign link.o_retry_cnt  = retry_q;
  assign link.o_lockout    = lockout;
  assign link.o_tx_led     = tx_led;

endmodule

// File: tb/tb_sfp_tx_link_ctrl.sv
// Directed bench for sfp_tx_link_ctrl with small slot/filter parameters.
module tb_sfp_tx_link_ctrl;

  logic clk;
  logic res_n;
  int   checks;
  int   failures;

  localparam logic [13:0] RST_OUTS = {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00};

  sfp_tx_link_ctrl_if link();

  sfp_tx_link_ctrl #(
    .P_DIS_SLOTS      (2),
    .P_WARM_SLOTS     (3),
    .P_SYNC_FRAMES    (2),
    .P_COMMA_PERIOD   (4),
    .P_FLT_FILT       (4),
    .P_FLT_HOLD_SLOTS (5),
    .P_STABLE_SLOTS   (6),
    .P_MAX_RETRY      (2)
  ) dut (
    .i_clk   (clk),
    .i_res_n (res_n),
    .link    (link)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [13:0] outs();
    return {link.o_state, link.o_sfp_tx_dis, link.o_drv_en, link.o_send_comma,
            link.o_data_valid, link.o_retry_cnt, link.o_lockout, link.o_tx_led};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe();
    link.i_slot_en = 1'b1;
    tick();
    link.i_slot_en = 1'b0;
    tick();
  endtask

  task automatic strobes(input int n);
    repeat (n) strobe();
  endtask

  task automatic fault_pulse();
    link.i_sfp_tx_flt = 1'b1;
    repeat (4) tick();
    link.i_sfp_tx_flt = 1'b0;
    tick();
    tick();
  endtask

  // From DISABLED with i_en=1: three fault entries in WARMUP, no stable period.
  task automatic to_lockout();
    strobes(3);
    fault_pulse();
    strobes(7);
    fault_pulse();
    strobes(7);
    fault_pulse();
  endtask

  task automatic test_reset();
    link.i_en = 1'b0;
    link.i_clr_lockout = 1'b0;
    link.i_slot_en = 1'b0;
    link.i_sfp_tx_flt = 1'b0;
    res_n = 1'b0;
    tick();
    tick();
    res_n = 1'b1;
    checks++;
    if (outs() !== RST_OUTS) begin
      failures++;
      $display("FAIL reset_outs got=%b exp=%b", outs(), RST_OUTS);
    end
    strobe();
    checks++;
    if (link.o_state !== 3'd0) begin
      failures++;
      $display("FAIL disabled_hold_en0 got=%0d exp=0", link.o_state);
    end
  endtask

  task automatic test_bringup();
    logic [2:0] exp_st [8] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4};
    int commas = 0;
    link.i_en = 1'b1;
    tick();
    tick();
    checks++;
    if (link.o_state !== 3'd0) begin
      failures++;
      $display("FAIL wait_for_strobe got=%0d exp=0", link.o_state);
    end
    for (int k = 0; k < 8; k++) begin
      strobe();
      checks++;
      if (link.o_state !== exp_st[k]) begin
        failures++;
        $display("FAIL bringup_state strobe=%0d got=%0d exp=%0d", k + 1, link.o_state, exp_st[k]);
      end
      if (link.o_send_comma) commas++;
      if (k == 0) begin
        checks++;
        if (link.o_tx_led !== 2'b11 || link.o_sfp_tx_dis !== 1'b1) begin
          failures++;
          $display("FAIL powerup_outs led=%b dis=%b exp led=11 dis=1", link.o_tx_led,
                   link.o_sfp_tx_dis);
        end
      end
      if (k == 2) begin
        checks++;
        if (link.o_sfp_tx_dis !== 1'b0 || link.o_drv_en !== 1'b0) begin
          failures++;
          $display("FAIL warmup_outs dis=%b drv=%b exp dis=0 drv=0", link.o_sfp_tx_dis,
                   link.o_drv_en);
        end
      end
      if (k == 5) begin
        checks++;
        if (link.o_drv_en !== 1'b1 || link.o_data_valid !== 1'b0) begin
          failures++;
          $display("FAIL sync_outs drv=%b dv=%b exp drv=1 dv=0", link.o_drv_en,
                   link.o_data_valid);
        end
      end
    end
    checks++;
    if (commas !== 2) begin
      failures++;
      $display("FAIL sync_comma_slots got=%0d exp=2", commas);
    end
    checks++;
    if ({link.o_send_comma, link.o_data_valid, link.o_tx_led} !== 4'b0110) begin
      failures++;
      $display("FAIL run_entry comma=%b dv=%b led=%b exp comma=0 dv=1 led=10",
               link.o_send_comma, link.o_data_valid, link.o_tx_led);
    end
  endtask

  task automatic test_comma_period();
    logic exp_c;
    for (int r = 1; r <= 12; r++) begin
      strobe();
      exp_c = ((r + 1) % 4 == 0);
      checks++;
      if (link.o_send_comma !== exp_c || link.o_data_valid !== !exp_c) begin
        failures++;
        $display("FAIL run_comma slot=%0d comma=%b dv=%b exp comma=%b dv=%b", r + 1,
                 link.o_send_comma, link.o_data_valid, exp_c, !exp_c);
      end
    end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 3; i++) begin
      link.i_sfp_tx_flt = 1'b1;
      #1;
      checks++;
      if (link.o_drv_en !== 1'b0 || link.o_state !== 3'd4) begin
        failures++;
        $display("FAIL glitch_drv clk=%0d drv=%b state=%0d exp drv=0 state=4", i,
                 link.o_drv_en, link.o_state);
      end
      tick();
    end
    link.i_sfp_tx_flt = 1'b0;
    #1;
    tick();
    checks++;
    if (link.o_drv_en !== 1'b1 || link.o_state !== 3'd4 || link.o_retry_cnt !== 4'd0) begin
      failures++;
      $display("FAIL glitch_after drv=%b state=%0d retry=%0d exp drv=1 state=4 retry=0",
               link.o_drv_en, link.o_state, link.o_retry_cnt);
    end
  endtask

  task automatic test_fault();
    link.i_sfp_tx_flt = 1'b1;
    repeat (3) tick();
    checks++;
    if (link.o_state !== 3'd4) begin
      failures++;
      $display("FAIL fault_early got=%0d exp=4", link.o_state);
    end
    tick();
    checks++;
    if ({link.o_state, link.o_retry_cnt, link.o_sfp_tx_dis, link.o_drv_en, link.o_tx_led}
        !== {3'd5, 4'd1, 1'b1, 1'b0, 2'b01}) begin
      failures++;
      $display("FAIL fault_entry state=%0d retry=%0d dis=%b drv=%b led=%b exp 5 1 1 0 01",
               link.o_state, link.o_retry_cnt, link.o_sfp_tx_dis, link.o_drv_en,
               link.o_tx_led);
    end
    link.i_sfp_tx_flt = 1'b0;
    tick();
    tick();
    strobes(4);
    checks++;
    if (link.o_state !== 3'd5) begin
      failures++;
      $display("FAIL fault_hold got=%0d exp=5", link.o_state);
    end
    strobe();
    checks++;
    if (link.o_state !== 3'd1) begin
      failures++;
      $display("FAIL fault_retry got=%0d exp=1", link.o_state);
    end
  endtask

  task automatic test_retry_clear();
    strobes(7);
    checks++;
    if (link.o_state !== 3'd4 || link.o_retry_cnt !== 4'd1) begin
      failures++;
      $display("FAIL rerun state=%0d retry=%0d exp state=4 retry=1", link.o_state,
               link.o_retry_cnt);
    end
    strobes(5);
    checks++;
    if (link.o_retry_cnt !== 4'd1) begin
      failures++;
      $display("FAIL stable_early got=%0d exp=1", link.o_retry_cnt);
    end
    strobe();
    checks++;
    if (link.o_retry_cnt !== 4'd0) begin
      failures++;
      $display("FAIL stable_clear got=%0d exp=0", link.o_retry_cnt);
    end
  endtask

  task automatic test_lockout();
    link.i_en = 1'b0;
    tick();
    checks++;
    if (link.o_state !== 3'd0) begin
      failures++;
      $display("FAIL en_low_disable got=%0d exp=0", link.o_state);
    end
    link.i_en = 1'b1;
    to_lockout();
    checks++;
    if ({link.o_state, link.o_lockout, link.o_tx_led, link.o_retry_cnt, link.o_sfp_tx_dis}
        !== {3'd6, 1'b1, 2'b01, 4'd3, 1'b1}) begin
      failures++;
      $display("FAIL lockout_outs state=%0d lock=%b led=%b retry=%0d dis=%b exp 6 1 01 3 1",
               link.o_state, link.o_lockout, link.o_tx_led, link.o_retry_cnt,
               link.o_sfp_tx_dis);
    end
    link.i_en = 1'b0;
    tick();
    strobe();
    checks++;
    if (link.o_state !== 3'd6) begin
      failures++;
      $display("FAIL lockout_sticky got=%0d exp=6", link.o_state);
    end
    link.i_clr_lockout = 1'b1;
    tick();
    link.i_clr_lockout = 1'b0;
    checks++;
    if ({link.o_state, link.o_retry_cnt, link.o_lockout} !== {3'd0, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL lockout_clear state=%0d retry=%0d lock=%b exp 0 0 0", link.o_state,
               link.o_retry_cnt, link.o_lockout);
    end
  endtask

  task automatic test_reset_mid();
    link.i_en = 1'b1;
    strobes(6);
    link.i_clr_lockout = 1'b1;
    tick();
    link.i_clr_lockout = 1'b0;
    checks++;
    if (link.o_state !== 3'd3) begin
      failures++;
      $display("FAIL clr_ignored got=%0d exp=3", link.o_state);
    end
    res_n = 1'b0;
    tick();
    checks++;
    if (outs() !== RST_OUTS) begin
      failures++;
      $display("FAIL reset_in_sync got=%b exp=%b", outs(), RST_OUTS);
    end
    res_n = 1'b1;
    to_lockout();
    res_n = 1'b0;
    tick();
    checks++;
    if (outs() !== RST_OUTS) begin
      failures++;
      $display("FAIL reset_in_lockout got=%b exp=%b", outs(), RST_OUTS);
    end
    res_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_bringup();
    test_comma_period();
    test_glitch();
    test_fault();
    test_retry_clear();
    test_lockout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
